// File: rtl/bool_sweep_ctrl.sv
// rtl/bool_sweep_ctrl.sv - sweeps a boolean block through all input vectors,
// captures its truth table and reports mismatches against an expected table.
module bool_sweep_ctrl #(
  parameter int N_IN        = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [2**N_IN-1:0]   exp_tt,
  input  logic                 z_in,
  output logic [N_IN-1:0]      vec,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   tt,
  output logic                 any_fail,
  output logic [N_IN:0]        fail_cnt,
  output logic [N_IN-1:0]      first_fail
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [N_IN-1:0] VEC_LAST  = '1;

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  state_t              state, nextState;
  logic [HW-1:0]       holdCnt;
  logic [2**N_IN-1:0]  expLatch;
  logic                mismatch;

  assign mismatch = (z_in != expLatch[vec]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) nextState = DRIVE;
      end
      DRIVE: begin
        busy = 1'b1;
        if (abort)                     nextState = IDLE;
        else if (holdCnt == HOLD_LAST) nextState = SAMPLE;
      end
      SAMPLE: begin
        busy = 1'b1;
        if (abort)                 nextState = IDLE;
        else if (vec == VEC_LAST)  nextState = DONE;
        else                       nextState = DRIVE;
      end
      DONE: begin
        done      = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec        <= '0;
      tt         <= '0;
      any_fail   <= 1'b0;
      fail_cnt   <= '0;
      first_fail <= '0;
      holdCnt    <= '0;
      expLatch   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            expLatch   <= exp_tt;
            tt         <= '0;
            any_fail   <= 1'b0;
            fail_cnt   <= '0;
            first_fail <= '0;
            vec        <= '0;
            holdCnt    <= '0;
          end
        end
        DRIVE: begin
          if (abort) begin
            vec     <= '0;
            holdCnt <= '0;
          end else begin
            holdCnt <= holdCnt + HW'(1);
          end
        end
        SAMPLE: begin
          // An aborted sample leaves the partial results exactly as they were.
          if (abort) begin
            vec     <= '0;
            holdCnt <= '0;
          end else begin
            tt[vec] <= z_in;
            if (mismatch) begin
              fail_cnt <= fail_cnt + (N_IN+1)'(1);
              any_fail <= 1'b1;
              if (!any_fail) first_fail <= vec;
            end
            if (vec != VEC_LAST) begin
              vec     <= vec + N_IN'(1);
              holdCnt <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bool_sweep_ctrl.sv
// tb/tb_bool_sweep_ctrl.sv - directed bench for bool_sweep_ctrl at HOLD_CYCLES 2 and 1.
module tb_bool_sweep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, start1, abort1, z1, busy1, done1, anyFail1;
  logic [15:0] exp1, tt1;
  logic [3:0]  vec1, firstFail1;
  logic [4:0]  failCnt1;

  logic        rst2, start2, abort2, z2, busy2, done2, anyFail2;
  logic [15:0] exp2, tt2;
  logic [3:0]  vec2, firstFail2;
  logic [4:0]  failCnt2;

  // Boolean block under control: z = a ^ d.
  assign z1 = vec1[3] ^ vec1[0];
  assign z2 = vec2[3] ^ vec2[0];

  bool_sweep_ctrl #(.N_IN(4), .HOLD_CYCLES(2)) dut1 (
    .clk(clk), .rst_n(rst1), .start(start1), .abort(abort1), .exp_tt(exp1),
    .z_in(z1), .vec(vec1), .busy(busy1), .done(done1), .tt(tt1),
    .any_fail(anyFail1), .fail_cnt(failCnt1), .first_fail(firstFail1)
  );

  bool_sweep_ctrl #(.N_IN(4), .HOLD_CYCLES(1)) dut2 (
    .clk(clk), .rst_n(rst2), .start(start2), .abort(abort2), .exp_tt(exp2),
    .z_in(z2), .vec(vec2), .busy(busy2), .done(done2), .tt(tt2),
    .any_fail(anyFail2), .fail_cnt(failCnt2), .first_fail(firstFail2)
  );

  logic        sel;
  logic        mBusy, mDone, mAny;
  logic [15:0] mTt;
  logic [3:0]  mVec, mFirst;
  logic [4:0]  mCnt;
  assign mBusy  = sel ? busy2 : busy1;
  assign mDone  = sel ? done2 : done1;
  assign mAny   = sel ? anyFail2 : anyFail1;
  assign mTt    = sel ? tt2 : tt1;
  assign mVec   = sel ? vec2 : vec1;
  assign mFirst = sel ? firstFail2 : firstFail1;
  assign mCnt   = sel ? failCnt2 : failCnt1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Full sweep on the selected instance, checking busy, vec tracking and done timing.
  task automatic runSweep(input logic [15:0] e);
    int hold, lat, vecBad, busyBad, expVec;
    hold    = sel ? 1 : 2;
    lat     = -1;
    vecBad  = 0;
    busyBad = 0;
    @(negedge clk);
    if (sel) begin exp2 = e; start2 = 1'b1; end
    else     begin exp1 = e; start1 = 1'b1; end
    @(posedge clk); #1;
    start1 = 1'b0; start2 = 1'b0;
    check("busy_after_accept", mBusy, 1);
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (mDone) begin lat = k; break; end
      expVec = k / (hold + 1);
      if (!mBusy) busyBad++;
      if (mVec !== expVec[3:0]) vecBad++;
    end
    check("done_latency", lat, 16 * (hold + 1));
    check("busy_during_sweep_drops", busyBad, 0);
    check("vec_tracking_errors", vecBad, 0);
    check("busy_in_done", mBusy, 0);
    check("vec_held_in_done", mVec, 15);
    @(posedge clk); #1;
    check("done_one_cycle", {mDone, mBusy}, 0);
  endtask

  typedef struct {
    logic [15:0] expTt;
    logic [15:0] tt;
    logic [4:0]  cnt;
    logic [3:0]  first;
    logic        any;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int k, doneCnt;
    logic found;

    tbl[0] = '{16'h55AA, 16'h55AA, 5'd0,  4'd0,  1'b0};
    tbl[1] = '{16'h55AB, 16'h55AA, 5'd1,  4'd0,  1'b1};
    tbl[2] = '{16'hAA55, 16'h55AA, 5'd16, 4'd0,  1'b1};
    tbl[3] = '{16'h55AE, 16'h55AA, 5'd1,  4'd2,  1'b1};
    tbl[4] = '{16'h55A8, 16'h55AA, 5'd1,  4'd1,  1'b1};
    tbl[5] = '{16'hD5AA, 16'h55AA, 5'd1,  4'd15, 1'b1};
    tbl[6] = '{16'h0000, 16'h55AA, 5'd8,  4'd1,  1'b1};
    tbl[7] = '{16'hFFFF, 16'h55AA, 5'd8,  4'd0,  1'b1};

    sel = 1'b0;
    rst1 = 1'b0; rst2 = 1'b0;
    start1 = 1'b0; start2 = 1'b0; abort1 = 1'b0; abort2 = 1'b0;
    exp1 = '0; exp2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_dut1", {vec1, busy1, done1, tt1, anyFail1, failCnt1, firstFail1}, 0);
    check("reset_dut2", {vec2, busy2, done2, tt2, anyFail2, failCnt2, firstFail2}, 0);
    @(negedge clk);
    rst1 = 1'b1; rst2 = 1'b1;
    @(posedge clk); #1;
    check("idle_after_reset", {busy1, done1}, 0);

    for (int i = 0; i < 8; i++) begin
      runSweep(tbl[i].expTt);
      check($sformatf("tt_%0d", i), mTt, tbl[i].tt);
      check($sformatf("fail_cnt_%0d", i), mCnt, tbl[i].cnt);
      check($sformatf("first_fail_%0d", i), mFirst, tbl[i].first);
      check($sformatf("any_fail_%0d", i), mAny, tbl[i].any);
    end

    // Abort while vec = 5 in DRIVE keeps partial results and never pulses done.
    @(negedge clk);
    exp1 = 16'h55AB; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    found = 1'b0;
    for (int j = 0; j < 100; j++) begin
      @(posedge clk); #1;
      if (vec1 == 4'd5) begin found = 1'b1; break; end
    end
    check("abort_reach_vec5", found, 1);
    abort1 = 1'b1;
    @(posedge clk); #1;
    abort1 = 1'b0;
    check("abort_busy", busy1, 0);
    check("abort_vec", vec1, 0);
    check("abort_tt", tt1, 16'h000A);
    check("abort_stats", {anyFail1, failCnt1, firstFail1}, {1'b1, 5'd1, 4'd0});
    doneCnt = 0;
    for (int j = 0; j < 60; j++) begin
      @(posedge clk); #1;
      if (done1) doneCnt++;
    end
    check("abort_no_done", doneCnt, 0);

    // Start and exp_tt change mid-sweep, then start held through the DONE cycle.
    @(negedge clk);
    exp1 = 16'h55AB; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    k = 0;
    found = 1'b0;
    doneCnt = 0;
    for (int j = 0; j < 100; j++) begin
      @(posedge clk); #1;
      k++;
      if (vec1 == 4'd7 && !found) begin
        found = 1'b1;
        start1 = 1'b1;
        exp1 = 16'h0000;
        @(posedge clk); #1;
        k++;
        start1 = 1'b0;
      end
      if (done1) break;
    end
    check("rebusy_reach_vec7", found, 1);
    check("rebusy_done_latency", k, 48);
    check("rebusy_done", done1, 1);
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    check("start_in_done_ignored", busy1, 0);
    if (done1) doneCnt++;
    for (int j = 0; j < 20; j++) begin
      @(posedge clk); #1;
      if (done1) doneCnt++;
    end
    check("rebusy_no_extra_done", doneCnt, 0);
    check("rebusy_tt", tt1, 16'h55AA);
    check("rebusy_stats", {anyFail1, failCnt1, firstFail1}, {1'b1, 5'd1, 4'd0});

    // HOLD_CYCLES = 1 instance: full sweep, reset at vec = 9, then a clean sweep.
    sel = 1'b1;
    runSweep(16'h55AA);
    check("h1_tt", tt2, 16'h55AA);
    @(negedge clk);
    exp2 = 16'h55AB; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    found = 1'b0;
    for (int j = 0; j < 100; j++) begin
      @(posedge clk); #1;
      if (vec2 == 4'd9) begin found = 1'b1; break; end
    end
    check("h1_reach_vec9", found, 1);
    check("h1_partial_tt", tt2, 16'h01AA);
    #2;
    rst2 = 1'b0;
    #1;
    check("h1_async_reset", {vec2, busy2, done2, tt2, anyFail2, failCnt2, firstFail2}, 0);
    @(negedge clk);
    rst2 = 1'b1;
    runSweep(16'h55A8);
    check("h1_post_reset_tt", tt2, 16'h55AA);
    check("h1_post_reset_stats", {anyFail2, failCnt2, firstFail2}, {1'b1, 5'd1, 4'd1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bool_sweep_ctrl.md
Name: bool_sweep_ctrl

Overview:
- Sequencer that sweeps a 4-input combinational boolean block through all 2^N_IN input vectors in ascending binary order.
- Waits a programmable settle time per vector, then captures the block output into a truth-table register.
- Compares the captured truth table against an expected table and reports mismatch statistics.
- Sits beside the boolean-equation datapath as its on-chip self-check and characterisation controller.

Parameters:
- N_IN, 4, number of function inputs; the sweep covers 2^N_IN vectors.
- HOLD_CYCLES, 2, settle cycles per vector before sampling; legal range is 1 or more.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a sweep; honoured only in IDLE
- abort  input  1  synchronous abort of a running sweep
- exp_tt  input  2^N_IN  expected truth table; bit i is the expected output for vector i
- z_in  input  1  output of the boolean block under control
- vec  output  N_IN  drive vector; vec[N_IN-1] drives a, then b, c, and vec[0] drives d
- busy  output  1  high from the cycle after start is accepted until the sweep ends
- done  output  1  one-cycle pulse when a sweep completes normally
- tt  output  2^N_IN  captured truth table
- any_fail  output  1  at least one mismatch in the last or current sweep
- fail_cnt  output  N_IN+1  number of mismatching vectors
- first_fail  output  N_IN  lowest mismatching vector index; 0 if there are no failures

Behaviour:
- Reset, asynchronous on rst_n low: state = IDLE; vec, tt, fail_cnt, first_fail and hold counter = 0; busy, done and any_fail = 0; latched expected table = 0.
- States are IDLE, DRIVE, SAMPLE and DONE.
- IDLE:
  - start high at a clock edge latches exp_tt internally.
  - Clears tt, fail_cnt, any_fail and first_fail; sets vec = 0 and hold counter = 0.
  - Moves to DRIVE; busy goes high.
  - A change on exp_tt after this point has no effect on the sweep.
- DRIVE: hold counter increments each cycle. When it reaches HOLD_CYCLES-1, the next state is SAMPLE.
- SAMPLE (one cycle):
  - tt[vec] <= z_in.
  - If z_in differs from the latched exp bit[vec]: fail_cnt increments; any_fail <= 1; if this is the first failure, first_fail <= vec.
  - If vec = 2^N_IN-1, the next state is DONE. Otherwise vec increments, the hold counter clears, and the next state is DRIVE.
- DONE: done = 1 and busy = 0 for exactly one cycle, then IDLE. vec holds its last value.
- Timing:
  - Vector i is sampled at edge (i+1)*(HOLD_CYCLES+1) after the start-accept edge.
  - done is high in the cycle following edge 2^N_IN*(HOLD_CYCLES+1).
  - Defaults give 48 cycles.
- start while busy: ignored and not queued.
- start in the DONE cycle: ignored.
- abort high in DRIVE or SAMPLE:
  - Next state is IDLE and busy drops.
  - No done pulse is issued.
  - tt and the fail statistics keep partial results; vec returns to 0.
  - A SAMPLE coinciding with abort does not update tt or the statistics.
- abort in IDLE or DONE: ignored; a DONE cycle still pulses done.
- abort and start together in IDLE: start wins.
- fail_cnt saturates naturally; its maximum value 2^N_IN fits in the N_IN+1 width.
- Reset mid-sweep: immediate return to the reset values above; all results are discarded.

Test Plan:
- Pass case: z_in = vec[3]^vec[0], exp_tt = 16'h55AA, start pulse.
  -> busy high from edge 0 until done; done pulses after edge 48; tt = 16'h55AA; fail_cnt = 0; any_fail = 0; first_fail = 0.
- Mismatch case: same function, exp_tt = 16'h55AB.
  -> tt = 16'h55AA; fail_cnt = 1; first_fail = 0; any_fail = 1.
- Multiple mismatches: same function, exp_tt = 16'hAA55.
  -> fail_cnt = 16, which also checks the saturation width; first_fail = 0.
- Abort: assert abort while vec = 5 in DRIVE.
  -> busy drops next cycle; no done pulse; vec = 0; tt bits 0..4 equal 5'b01010 and bits 5..15 = 0.
- Start while busy and exp_tt change: pulse start at vec = 7 and change exp_tt mid-sweep.
  -> the sweep continues unaffected; a single done pulse after edge 48; results match the originally latched table.
- HOLD_CYCLES=1 variant with a mid-sweep reset:
  -> vec advances every 2 cycles and done follows edge 32; rst_n low at vec = 9 immediately zeroes all outputs; the next start completes normally.
